// File: rtl/pipe_fixedpoint_mac.sv
// Pipelined signed fixed-point multiply-accumulate: register operands, form the exact product,
// then round to the output format and accumulate framed sets with saturate or wrap on overflow.
module pipe_fixedpoint_mac #(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 12,
  parameter int WOF   = 6,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_first,
  input  logic                 i_last,
  input  logic [WIIA+WIFA-1:0] ina,
  input  logic [WIIB+WIFB-1:0] inb,
  output logic                 o_valid,
  output logic [WOI+WOF-1:0]   out,
  output logic                 upflow,
  output logic                 downflow
);

  localparam int WA = WIIA + WIFA;
  localparam int WB = WIIB + WIFB;
  localparam int WO = WOI + WOF;
  localparam int WP = WA + WB;
  localparam int PF = WIFA + WIFB;
  // Rounded product keeps one spare MSB so the +0.5 LSB bias can never wrap.
  localparam int RW = (WOF >= PF) ? (WP + WOF - PF) : (WP + 1);
  localparam int SW = ((RW > WO) ? RW : WO) + 1;
  localparam int STAGES = 1;

  localparam logic [WO-1:0] OMAX = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] OMIN = {1'b1, {(WO-1){1'b0}}};

  typedef struct packed {
    logic          first;
    logic          last;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
  } beat_t;

  beat_t                  s1;
  logic [STAGES:0]        vld_pipe;
  logic                   s2_first;
  logic                   s2_last;
  logic signed [WP-1:0]   p_d;
  logic signed [WP-1:0]   p_q;
  logic signed [RW-1:0]   r_full;
  logic signed [WO-1:0]   acc;
  logic signed [WO-1:0]   base;
  logic signed [WO-1:0]   acc_nxt;
  logic signed [SW-1:0]   s_sum;
  logic signed [SW-1:0]   s_max;
  logic signed [SW-1:0]   s_min;
  logic [1:0]             flags;
  logic [1:0]             flg_nxt;
  logic                   up;
  logic                   dn;

  // Stage 1: operand capture, gated by beat valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], i_valid};
      if (i_valid) s1 <= '{first: i_first, last: i_last, a: ina, b: inb};
    end
  end

  // Stage 2: exact full-width product
  assign p_d = WP'($signed(s1.a)) * WP'($signed(s1.b));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q      <= '0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      p_q      <= p_d;
      s2_first <= s1.first;
      s2_last  <= s1.last;
    end
  end

  // Stage 3: reduce product to the output fraction width
  generate
    if (WOF >= PF) begin : g_pad
      assign r_full = RW'(p_q) <<< (WOF - PF);
    end else begin : g_rnd
      localparam int SH = PF - WOF;
      localparam logic signed [WP:0] HALF = (ROUND != 0) ? ((WP+1)'(1) <<< (SH - 1)) : '0;
      logic signed [WP:0] p_rnd;
      assign p_rnd  = (WP+1)'(p_q) + HALF;
      assign r_full = p_rnd >>> SH;
    end
  endgenerate

  assign s_max = SW'($signed(OMAX));
  assign s_min = SW'($signed(OMIN));

  always_comb begin
    base    = s2_first ? '0 : acc;
    s_sum   = SW'(r_full) + SW'(base);
    up      = (s_sum > s_max);
    dn      = (s_sum < s_min);
    acc_nxt = s_sum[WO-1:0];
    if (ROOF != 0) begin
      if (up) acc_nxt = OMAX;
      if (dn) acc_nxt = OMIN;
    end
    flg_nxt = s2_first ? {up, dn} : (flags | {up, dn});
  end

  // Accumulator, sticky flags and the framed result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      flags    <= '0;
      o_valid  <= 1'b0;
      out      <= '0;
      upflow   <= 1'b0;
      downflow <= 1'b0;
    end else begin
      o_valid <= vld_pipe[STAGES] & s2_last;
      if (vld_pipe[STAGES]) begin
        acc   <= acc_nxt;
        flags <= flg_nxt;
        if (s2_last) begin
          out                <= acc_nxt;
          {upflow, downflow} <= flg_nxt;
        end
      end
    end
  end

endmodule
